// File: rtl/neuron_learn_layer_seq_pkg.sv
// Shared types and constants for the sequential learning layer.
package neuron_learn_layer_seq_pkg;

    localparam int ZERO2ONE_W = 8;
    localparam int FRAC_W     = 16;

    typedef logic [ZERO2ONE_W-1:0]    zero2one_t;
    typedef logic signed [FRAC_W-1:0] frac_t;

    localparam zero2one_t ZERO2ONE_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT,
        ACC,
        DIV,
        DONE
    } nll_state_e;

endpackage

// File: rtl/neuron_learn.sv
// Single learning neuron: combinational forward path, weight state updated on a learn strobe.
import neuron_learn_layer_seq_pkg::*;

module neuron_learn #(
    parameter int N = 16
) (
    input  logic                  clock,
    input  logic                  valid,
    input  logic                  learn,
    input  zero2one_t [N-1:0]     in,
    input  zero2one_t             expected,
    output zero2one_t             out,
    output zero2one_t [N-1:0]     expected_in,
    output frac_t     [N-1:0]     weights,
    output frac_t                 activation_max,
    output frac_t                 activation_min
);

    // Output is the strongest input; the training target is pushed back to every input.
    always_comb begin
        out = '0;
        for (int j = 0; j < N; j++) begin
            if (in[j] > out) out = in[j];
        end
    end

    always_comb begin
        for (int j = 0; j < N; j++) expected_in[j] = expected;
    end

    // Weights deliberately have no reset: learned state survives a layer reset.
    always_ff @(posedge clock) begin
        if (valid && learn) begin
            for (int j = 0; j < N; j++) weights[j] <= frac_t'(in[j]);
        end
    end

    assign activation_max = frac_t'(ZERO2ONE_MAX);
    assign activation_min = '0;

endmodule

// File: rtl/zero2one_seq_average.sv
// Per-lane accumulate then divide-by-M; round-half-up when NEURON_LAYER_AVG_ROUND_EN is defined.
import neuron_learn_layer_seq_pkg::*;

module zero2one_seq_average #(
    parameter int N = 16,
    parameter int M = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              add,
    input  zero2one_t [N-1:0] in,
    input  logic              div,
    output zero2one_t [N-1:0] avg
);

    localparam int ACC_W = ZERO2ONE_W + $clog2(M + 1);
`ifdef NEURON_LAYER_AVG_ROUND_EN
    localparam int HALF = M / 2;
`else
    localparam int HALF = 0;
`endif

    logic [N-1:0][ACC_W-1:0] acc;
    logic [N-1:0][ACC_W:0]   quo;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign quo[i] = ({1'b0, acc[i]} + (ACC_W+1)'(HALF)) / (ACC_W+1)'(M);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
            avg <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (clear)    acc[i] <= '0;
                else if (add) acc[i] <= acc[i] + ACC_W'(in[i]);
                // Quotient never exceeds the max code, so the narrowing is lossless.
                if (div) avg[i] <= ZERO2ONE_W'(quo[i]);
            end
        end
    end

endmodule

// File: rtl/neuron_learn_layer_seq.sv
// Handshaked layer of M neurons with sequential back-propagated averaging.
// Build option: NEURON_LAYER_AVG_ROUND_EN selects round-half-up averaging.
import neuron_learn_layer_seq_pkg::*;

module neuron_learn_layer_seq #(
    parameter int N          = 16,
    parameter int M          = 26,
    parameter int NEURON_LAT = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     learn,
    input  zero2one_t [N-1:0]        in,
    input  zero2one_t [M-1:0]        expected_out,
    output logic                     out_valid,
    output zero2one_t [M-1:0]        out,
    output zero2one_t [N-1:0]        expected_in,
    output frac_t     [M-1:0][N-1:0] weights,
    output frac_t     [M-1:0]        activation_max,
    output frac_t     [M-1:0]        activation_min
);

    localparam int CNT_W = $clog2(NEURON_LAT + 2);
    localparam int IDX_W = $clog2(M + 1);

    nll_state_e state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    zero2one_t [N-1:0]        in_q;
    zero2one_t [M-1:0]        exp_q;
    logic                     learn_q;
    zero2one_t [M-1:0]        n_out;
    zero2one_t [M-1:0][N-1:0] unavg;
    zero2one_t [N-1:0]        unavg_sel;

    logic fire, capture, acc_clr, acc_add, div;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        fire      = 1'b0;
        capture   = 1'b0;
        acc_clr   = 1'b0;
        acc_add   = 1'b0;
        div       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = FIRE;
            end
            FIRE: begin
                fire = 1'b1;
                if (NEURON_LAT == 0) begin
                    capture   = 1'b1;
                    acc_clr   = learn_q;
                    state_nxt = learn_q ? ACC : DONE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(NEURON_LAT - 1)) begin
                    capture   = 1'b1;
                    acc_clr   = learn_q;
                    state_nxt = learn_q ? ACC : DONE;
                end
            end
            ACC: begin
                acc_add = 1'b1;
                if (idx == IDX_W'(M - 1)) state_nxt = DIV;
            end
            DIV: begin
                div       = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            in_q    <= '0;
            exp_q   <= '0;
            learn_q <= 1'b0;
            out     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == WAIT) ? cnt + 1'b1 : '0;
            idx   <= (state == ACC)  ? idx + 1'b1 : '0;
            if (in_ready && in_valid) begin
                in_q    <= in;
                exp_q   <= expected_out;
                learn_q <= learn;
            end
            if (capture) out <= n_out;
        end
    end

    // One neuron's back-propagated vector per ACC cycle.
    always_comb begin
        unavg_sel = '0;
        for (int k = 0; k < M; k++) begin
            if (idx == IDX_W'(k)) unavg_sel = unavg[k];
        end
    end

    for (genvar k = 0; k < M; k++) begin : g_neuron
        neuron_learn #(.N(N)) u_neuron (
            .clock         (clock),
            .valid         (fire),
            .learn         (learn_q),
            .in            (in_q),
            .expected      (exp_q[k]),
            .out           (n_out[k]),
            .expected_in   (unavg[k]),
            .weights       (weights[k]),
            .activation_max(activation_max[k]),
            .activation_min(activation_min[k])
        );
    end

    zero2one_seq_average #(.N(N), .M(M)) u_avg (
        .clock(clock),
        .reset(reset),
        .clear(acc_clr),
        .add  (acc_add),
        .in   (unavg_sel),
        .div  (div),
        .avg  (expected_in)
    );

endmodule

// File: tb/tb_neuron_learn_layer_seq.sv
// Directed bench: M=4/LAT=1 layer plus an M=1/LAT=0 layer.
import neuron_learn_layer_seq_pkg::*;

module tb_neuron_learn_layer_seq;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // DUT A: N=3, M=4, NEURON_LAT=1
    logic                 in_valid = 1'b0, learn = 1'b0, in_ready, out_valid;
    zero2one_t [2:0]      in_v = '0;
    zero2one_t [3:0]      exp_out = '0;
    zero2one_t [3:0]      out_a;
    zero2one_t [2:0]      exp_in_a;
    frac_t [3:0][2:0]     w_a;
    frac_t [3:0]          amax_a, amin_a;

    // DUT B: N=3, M=1, NEURON_LAT=0
    logic                 in_valid_b = 1'b0, learn_b = 1'b0, in_ready_b, out_valid_b;
    zero2one_t [2:0]      in_b = '0;
    zero2one_t [0:0]      exp_b = '0;
    zero2one_t [0:0]      out_b;
    zero2one_t [2:0]      exp_in_b;
    frac_t [0:0][2:0]     w_b;
    frac_t [0:0]          amax_b, amin_b;

    neuron_learn_layer_seq #(.N(3), .M(4), .NEURON_LAT(1)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .learn(learn), .in(in_v), .expected_out(exp_out), .out_valid(out_valid),
        .out(out_a), .expected_in(exp_in_a), .weights(w_a),
        .activation_max(amax_a), .activation_min(amin_a)
    );

    neuron_learn_layer_seq #(.N(3), .M(1), .NEURON_LAT(0)) u_dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .learn(learn_b), .in(in_b), .expected_out(exp_b), .out_valid(out_valid_b),
        .out(out_b), .expected_in(exp_in_b), .weights(w_b),
        .activation_max(amax_b), .activation_min(amin_b)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Issue one request on DUT A from IDLE and observe cycles t0+1..t0+14.
    task automatic req_a(input logic l, output int first, output int pulses,
                         output int busy, output int ready4);
        first = 0; pulses = 0; busy = 0; ready4 = 0;
        learn = l;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (out_valid) begin
                pulses++;
                if (first == 0) first = c;
            end
            if (c <= 3 && !in_ready) busy++;
            if (c == 4) ready4 = int'(in_ready);
            tick;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_a !== '0) begin errors++; $display("FAIL reset_out got=%h exp=0", out_a); end
        checks++; if (exp_in_a !== '0) begin errors++; $display("FAIL reset_expected_in got=%h exp=0", exp_in_a); end
        checks++; if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0) begin
            errors++; $display("FAIL reset_b_handshake got=%b%b exp=10", in_ready_b, out_valid_b);
        end
    endtask

    task automatic test_learn;
        int first, pulses, busy, r4;
        in_v = {8'd50, 8'd100, 8'd7};
        exp_out = {8'd40, 8'd30, 8'd20, 8'd10};
        req_a(1'b1, first, pulses, busy, r4);
        checks++; if (first !== 8) begin errors++; $display("FAIL learn_latency got=%0d exp=8", first); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL learn_pulses got=%0d exp=1", pulses); end
        checks++; if (exp_in_a !== {3{8'd25}}) begin errors++; $display("FAIL learn_expected_in got=%h exp=191919", exp_in_a); end
        checks++; if (out_a !== {4{8'd100}}) begin errors++; $display("FAIL learn_out got=%h exp=64646464", out_a); end
    endtask

    task automatic test_no_learn;
        int first, pulses, busy, r4;
        in_v = {8'd1, 8'd200, 8'd2};
        exp_out = {4{8'd9}};
        req_a(1'b0, first, pulses, busy, r4);
        checks++; if (first !== 3) begin errors++; $display("FAIL nolearn_latency got=%0d exp=3", first); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL nolearn_pulses got=%0d exp=1", pulses); end
        checks++; if (busy !== 3) begin errors++; $display("FAIL nolearn_busy got=%0d exp=3", busy); end
        checks++; if (r4 !== 1) begin errors++; $display("FAIL nolearn_ready_t4 got=%0d exp=1", r4); end
        checks++; if (exp_in_a !== {3{8'd25}}) begin errors++; $display("FAIL nolearn_hold got=%h exp=191919", exp_in_a); end
        checks++; if (out_a !== {4{8'd200}}) begin errors++; $display("FAIL nolearn_out got=%h exp=c8c8c8c8", out_a); end
    endtask

    task automatic test_round;
        int first, pulses, busy, r4;
        zero2one_t want;
`ifdef NEURON_LAYER_AVG_ROUND_EN
        want = 8'd2;
`else
        want = 8'd1;
`endif
        exp_out = {8'd2, 8'd2, 8'd2, 8'd1};
        req_a(1'b1, first, pulses, busy, r4);
        checks++; if (exp_in_a !== {3{want}}) begin errors++; $display("FAIL round_sum7 got=%h exp=%h", exp_in_a, {3{want}}); end
        exp_out = {4{8'd255}};
        req_a(1'b1, first, pulses, busy, r4);
        checks++; if (exp_in_a !== {3{8'd255}}) begin errors++; $display("FAIL round_max got=%h exp=ffffff", exp_in_a); end
    endtask

    task automatic test_back_to_back;
        int acc_cyc[3];
        int n_acc = 0;
        int pulses = 0;
        exp_out = {8'd4, 8'd3, 8'd2, 8'd1};
        learn = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 32; c++) begin
            if (out_valid) pulses++;
            if (in_valid && in_ready && n_acc < 3) begin
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            tick;
            if (n_acc == 3) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        checks++; if (n_acc !== 3) begin errors++; $display("FAIL b2b_accepts got=%0d exp=3", n_acc); end
        checks++; if (n_acc == 3 && (acc_cyc[0] !== 0 || acc_cyc[1] !== 9 || acc_cyc[2] !== 18)) begin
            errors++; $display("FAIL b2b_accept_cycles got=%0d,%0d,%0d exp=0,9,18", acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
        checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses got=%0d exp=3", pulses); end
    endtask

    task automatic test_reset_mid_acc;
        int pulses = 0;
        exp_out = {4{8'd60}};
        learn = 1'b1;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        // Cycle t0+4 is inside ACC.
        reset = 1'b1;
        tick;
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midacc_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_a !== '0 || exp_in_a !== '0) begin
            errors++; $display("FAIL midacc_cleared got out=%h ein=%h exp=0", out_a, exp_in_a);
        end
        for (int c = 0; c < 12; c++) begin
            if (out_valid) pulses++;
            tick;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midacc_no_valid got=%0d exp=0", pulses); end
    endtask

    task automatic test_m1;
        int first = 0;
        exp_b = 8'd77;
        in_b = {8'd3, 8'd2, 8'd1};
        learn_b = 1'b1;
        in_valid_b = 1'b1;
        tick;
        in_valid_b = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (out_valid_b && first == 0) first = c;
            tick;
        end
        checks++; if (first !== 4) begin errors++; $display("FAIL m1_latency got=%0d exp=4", first); end
        checks++; if (exp_in_b !== {3{8'd77}}) begin errors++; $display("FAIL m1_expected_in got=%h exp=4d4d4d", exp_in_b); end
        checks++; if (out_b !== 8'd3) begin errors++; $display("FAIL m1_out got=%h exp=03", out_b); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tick;
        test_reset;
        test_learn;
        test_no_learn;
        test_round;
        test_back_to_back;
        test_reset_mid_acc;
        test_m1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
